// File: rtl/bs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : bs_pkg                                                     |
// | Description : Shared opcode, ALU-op and sequencer-state definitions for  |
// |               the bit-serial CPU control path.                           |
// | Revision    : 1.0 - initial parametrised sequencer release               |
// +--------------------------------------------------------------------------+
package bs_pkg;

    typedef logic [3:0] opcode_t;
    typedef logic [2:0] alu_op_t;

    // Instruction opcodes
    localparam opcode_t OP_ADD     = 4'h0;
    localparam opcode_t OP_SUB     = 4'h1;
    localparam opcode_t OP_SLLI    = 4'h2;
    localparam opcode_t OP_SRLI    = 4'h3;
    localparam opcode_t OP_OR      = 4'h4;
    localparam opcode_t OP_AND     = 4'h5;
    localparam opcode_t OP_XOR     = 4'h6;
    localparam opcode_t OP_LOAD    = 4'h7;
    localparam opcode_t OP_ADDI    = 4'h8;
    localparam opcode_t OP_SUBI    = 4'h9;
    localparam opcode_t OP_ORI     = 4'hA;
    localparam opcode_t OP_ANDI    = 4'hB;
    localparam opcode_t OP_XORI    = 4'hC;
    localparam opcode_t OP_LOADI   = 4'hD;
    localparam opcode_t OP_STORE   = 4'hE;
    localparam opcode_t OP_ILLEGAL = 4'hF;

    // ALU operation select encodings
    localparam alu_op_t ALU_ADD = 3'd0;
    localparam alu_op_t ALU_SUB = 3'd1;
    localparam alu_op_t ALU_XOR = 3'd2;
    localparam alu_op_t ALU_AND = 3'd3;
    localparam alu_op_t ALU_OR  = 3'd4;
    localparam alu_op_t ALU_SLL = 3'd5;
    localparam alu_op_t ALU_SRL = 3'd6;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        SHIFT  = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bs_ctrl_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : bs_ctrl_seq_if                                             |
// | Description : Instruction fetch handshake between fetch/load logic       |
// |               (master) and the control sequencer (slave).                |
// | Revision    : 1.0 - initial parametrised sequencer release               |
// +--------------------------------------------------------------------------+
interface bs_ctrl_seq_if;
    logic       inst_valid;
    logic [3:0] opcode;
    logic       inst_ready;

    modport master (
        output inst_valid,
        output opcode,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  opcode,
        output inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/bs_alu_op_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bs_alu_op_decode                                           |
// | Description : Pure combinational opcode classifier: ALU op select plus   |
// |               load / store / illegal flags.                              |
// | Revision    : 1.0 - initial parametrised sequencer release               |
// +--------------------------------------------------------------------------+
module bs_alu_op_decode
    import bs_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic       is_load,
    output logic       is_store,
    output logic       is_illegal
);

    // Map each opcode to its ALU function and instruction class
    always_comb begin
        alu_op     = ALU_ADD;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI:   alu_op     = ALU_ADD;
            OP_SUB, OP_SUBI:   alu_op     = ALU_SUB;
            OP_XOR, OP_XORI:   alu_op     = ALU_XOR;
            OP_AND, OP_ANDI:   alu_op     = ALU_AND;
            OP_OR,  OP_ORI:    alu_op     = ALU_OR;
            OP_SLLI:           alu_op     = ALU_SLL;
            OP_SRLI:           alu_op     = ALU_SRL;
            OP_LOAD, OP_LOADI: is_load    = 1'b1;
            OP_STORE:          is_store   = 1'b1;
            OP_ILLEGAL:        is_illegal = 1'b1;
            default:           alu_op     = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bs_ctrl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bs_ctrl_seq                                                |
// | Description : Parametrised control sequencer for the bit-serial CPU.     |
// |               Fetches over valid/ready, runs DATA_W serial bit cycles    |
// |               per ALU op with its own bit counter, supports abort and    |
// |               illegal-opcode trapping. All outputs are registered.       |
// | Revision    : 1.0 - initial parametrised sequencer release               |
// +--------------------------------------------------------------------------+
module bs_ctrl_seq
    import bs_pkg::*;
#(
    parameter int DATA_W   = 8,                 // must be >= 2
    parameter int CNT_W    = $clog2(DATA_W),
    parameter int AUTO_RUN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    bs_ctrl_seq_if.slave     fetch,
    input  logic             step,
    input  logic             abort,
    output logic             busy,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    output logic             carry_en,
    output logic             reg_shift_en,
    output logic             acc_write_en,
    output logic             acc_load_en,
    output logic             reg_store_en,
    output logic [CNT_W-1:0] bit_idx,
    output logic             done,
    output logic             illegal
);

    localparam bit             C_AUTO     = (AUTO_RUN != 0);
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    // DATA_W reduced modulo 2**CNT_W; the subtraction below wraps correctly
    // because the true result is always below DATA_W.
    localparam logic [CNT_W-1:0] C_DATA_W_M = CNT_W'(DATA_W);

    state_t           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             inst_ready_q, inst_ready_d;
    logic             busy_q, busy_d;
    logic             alu_start_q, alu_start_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             carry_en_q, carry_en_d;
    logic             reg_shift_en_q, reg_shift_en_d;
    logic             acc_write_en_q, acc_write_en_d;
    logic             acc_load_en_q, acc_load_en_d;
    logic             reg_store_en_q, reg_store_en_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    logic [2:0]       dec_alu_op;
    logic             dec_load;
    logic             dec_store;
    logic             dec_illegal;
    logic             dec_alu;

    // Decoding the next-cycle opcode lets the registered outputs line up with
    // the state they belong to; outside IDLE opcode_d equals opcode_q.
    bs_alu_op_decode u_dec (
        .opcode     (opcode_d),
        .alu_op     (dec_alu_op),
        .is_load    (dec_load),
        .is_store   (dec_store),
        .is_illegal (dec_illegal)
    );

    assign dec_alu = !(dec_load || dec_store || dec_illegal);

    // Next-state, opcode latch and bit counter; abort overrides every transition
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (fetch.inst_valid && (C_AUTO || step)) begin
                    state_d  = DECODE;
                    opcode_d = fetch.opcode;
                end
            end
            DECODE: begin
                if (dec_alu) begin
                    state_d = SHIFT;
                    cnt_d   = C_CNT_INIT;
                end else begin
                    state_d = DONE;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - C_ONE;
                if (cnt_q == C_ONE) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Moore output decode of the next state, registered below. Bit 0 is
    // shifted in DECODE, so SHIFT covers bits 1..DATA_W-1.
    always_comb begin
        inst_ready_d   = (state_d == IDLE);
        busy_d         = (state_d != IDLE);
        alu_start_d    = (state_d == DECODE) && dec_alu;
        alu_op_d       = ((state_d == DECODE) || (state_d == SHIFT) || (state_d == WRITE))
                         ? dec_alu_op : ALU_ADD;
        carry_en_d     = ((state_d == DECODE) && dec_alu) || (state_d == SHIFT) || (state_d == WRITE);
        reg_shift_en_d = ((state_d == DECODE) && dec_alu) || (state_d == SHIFT);
        acc_write_en_d = (state_d == SHIFT) || (state_d == WRITE);
        acc_load_en_d  = (state_d == DECODE) && dec_load;
        reg_store_en_d = (state_d == DECODE) && dec_store;
        bit_idx_d      = (state_d == SHIFT) ? (C_DATA_W_M - cnt_d) : '0;
        done_d         = (state_d == DONE);
        illegal_d      = (state_d == DONE) && dec_illegal;
    end

    // State, opcode, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            opcode_q       <= '0;
            cnt_q          <= '0;
            inst_ready_q   <= 1'b1;
            busy_q         <= 1'b0;
            alu_start_q    <= 1'b0;
            alu_op_q       <= '0;
            carry_en_q     <= 1'b0;
            reg_shift_en_q <= 1'b0;
            acc_write_en_q <= 1'b0;
            acc_load_en_q  <= 1'b0;
            reg_store_en_q <= 1'b0;
            bit_idx_q      <= '0;
            done_q         <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            cnt_q          <= cnt_d;
            inst_ready_q   <= inst_ready_d;
            busy_q         <= busy_d;
            alu_start_q    <= alu_start_d;
            alu_op_q       <= alu_op_d;
            carry_en_q     <= carry_en_d;
            reg_shift_en_q <= reg_shift_en_d;
            acc_write_en_q <= acc_write_en_d;
            acc_load_en_q  <= acc_load_en_d;
            reg_store_en_q <= reg_store_en_d;
            bit_idx_q      <= bit_idx_d;
            done_q         <= done_d;
            illegal_q      <= illegal_d;
        end
    end

    assign fetch.inst_ready = inst_ready_q;
    assign busy             = busy_q;
    assign alu_start        = alu_start_q;
    assign alu_op           = alu_op_q;
    assign carry_en         = carry_en_q;
    assign reg_shift_en     = reg_shift_en_q;
    assign acc_write_en     = acc_write_en_q;
    assign acc_load_en      = acc_load_en_q;
    assign reg_store_en     = reg_store_en_q;
    assign bit_idx          = bit_idx_q;
    assign done             = done_q;
    assign illegal          = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_bs_ctrl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bs_ctrl_seq                                             |
// | Description : Self-checking bench for bs_ctrl_seq: three instances       |
// |               (8-bit step, 8-bit auto-run, 16-bit step) compared every   |
// |               cycle against a cycle-offset model, plus directed literals.|
// | Revision    : 1.0 - initial parametrised sequencer release               |
// +--------------------------------------------------------------------------+
module tb_bs_ctrl_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bs_ctrl_seq_if if8 ();
    bs_ctrl_seq_if ifa ();
    bs_ctrl_seq_if if16 ();

    logic       stp [3];
    logic       abt [3];
    logic       busy_o [3];
    logic       alu_start_o [3];
    logic [2:0] alu_op_o [3];
    logic       carry_o [3];
    logic       shift_o [3];
    logic       accw_o [3];
    logic       accl_o [3];
    logic       store_o [3];
    logic       done_o [3];
    logic       ill_o [3];
    logic [2:0] bit_idx8;
    logic [2:0] bit_idxa;
    logic [3:0] bit_idx16;

    bs_ctrl_seq #(.DATA_W(8), .AUTO_RUN(0)) u8 (
        .clk(clk), .rst_n(rst_n), .fetch(if8), .step(stp[0]), .abort(abt[0]),
        .busy(busy_o[0]), .alu_start(alu_start_o[0]), .alu_op(alu_op_o[0]),
        .carry_en(carry_o[0]), .reg_shift_en(shift_o[0]), .acc_write_en(accw_o[0]),
        .acc_load_en(accl_o[0]), .reg_store_en(store_o[0]), .bit_idx(bit_idx8),
        .done(done_o[0]), .illegal(ill_o[0])
    );

    bs_ctrl_seq #(.DATA_W(8), .AUTO_RUN(1)) ua (
        .clk(clk), .rst_n(rst_n), .fetch(ifa), .step(stp[1]), .abort(abt[1]),
        .busy(busy_o[1]), .alu_start(alu_start_o[1]), .alu_op(alu_op_o[1]),
        .carry_en(carry_o[1]), .reg_shift_en(shift_o[1]), .acc_write_en(accw_o[1]),
        .acc_load_en(accl_o[1]), .reg_store_en(store_o[1]), .bit_idx(bit_idxa),
        .done(done_o[1]), .illegal(ill_o[1])
    );

    bs_ctrl_seq #(.DATA_W(16), .AUTO_RUN(0)) u16 (
        .clk(clk), .rst_n(rst_n), .fetch(if16), .step(stp[2]), .abort(abt[2]),
        .busy(busy_o[2]), .alu_start(alu_start_o[2]), .alu_op(alu_op_o[2]),
        .carry_en(carry_o[2]), .reg_shift_en(shift_o[2]), .acc_write_en(accw_o[2]),
        .acc_load_en(accl_o[2]), .reg_store_en(store_o[2]), .bit_idx(bit_idx16),
        .done(done_o[2]), .illegal(ill_o[2])
    );

    // ---------------- reference model: instruction progress per instance ----
    // m_k is the 1-based cycle number after the accepting edge.
    bit         m_act [3];
    int         m_k   [3];
    logic [3:0] m_op  [3];
    int         dw    [3] = '{8, 8, 16};
    bit         autorun [3] = '{1'b0, 1'b1, 1'b0};
    bit         cmp_en = 1'b0;
    bit         ua_win = 1'b0;
    int         ua_last = -1;

    function automatic logic [2:0] ref_alu(logic [3:0] op);
        case (op)
            4'h0, 4'h8: return 3'd0;
            4'h1, 4'h9: return 3'd1;
            4'h6, 4'hC: return 3'd2;
            4'h5, 4'hB: return 3'd3;
            4'h4, 4'hA: return 3'd4;
            4'h2:       return 3'd5;
            4'h3:       return 3'd6;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic bit is_alu(logic [3:0] op);
        return !(op inside {4'h7, 4'hD, 4'hE, 4'hF});
    endfunction

    function automatic int total_len(int i);
        return is_alu(m_op[i]) ? dw[i] + 2 : 2;
    endfunction

    function automatic logic in_valid(int i);
        case (i)
            0:       return if8.inst_valid;
            1:       return ifa.inst_valid;
            default: return if16.inst_valid;
        endcase
    endfunction

    function automatic logic [3:0] in_op(int i);
        case (i)
            0:       return if8.opcode;
            1:       return ifa.opcode;
            default: return if16.opcode;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_act[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (abt[i] || (m_k[i] == total_len(i))) m_act[i] <= 1'b0;
                else                                    m_k[i]   <= m_k[i] + 1;
            end else if (in_valid(i) && (autorun[i] || stp[i])) begin
                m_act[i] <= 1'b1;
                m_k[i]   <= 1;
                m_op[i]  <= in_op(i);
            end
        end
    end

    // {ready,busy,start,alu_op[3],carry,shift,accw,accl,store,bit_idx[4],done,illegal}
    function automatic logic [16:0] exp_vec(int i);
        logic ir, bz, st, ce, se, aw, al, rs, dn, il;
        logic [2:0] ao;
        logic [3:0] bi;
        logic [3:0] op;
        int k, n;
        ir = 1'b1; bz = 1'b0; st = 1'b0; ce = 1'b0; se = 1'b0; aw = 1'b0;
        al = 1'b0; rs = 1'b0; dn = 1'b0; il = 1'b0; ao = 3'd0; bi = 4'd0;
        if (m_act[i]) begin
            k  = m_k[i];
            n  = dw[i];
            op = m_op[i];
            ir = 1'b0;
            bz = 1'b1;
            if (is_alu(op)) begin
                st = (k == 1);
                se = (k <= n);
                aw = (k >= 2) && (k <= n + 1);
                ce = (k <= n + 1);
                bi = ((k >= 2) && (k <= n)) ? 4'(k - 1) : 4'd0;
                ao = (k <= n + 1) ? ref_alu(op) : 3'd0;
                dn = (k == n + 2);
            end else begin
                al = (k == 1) && ((op == 4'h7) || (op == 4'hD));
                rs = (k == 1) && (op == 4'hE);
                ao = (k == 1) ? ref_alu(op) : 3'd0;
                dn = (k == 2);
                il = (k == 2) && (op == 4'hF);
            end
        end
        return {ir, bz, st, ao, ce, se, aw, al, rs, bi, dn, il};
    endfunction

    function automatic logic [16:0] get_act(int i);
        logic       ir;
        logic [3:0] bi;
        case (i)
            0:       begin ir = if8.inst_ready;  bi = {1'b0, bit_idx8}; end
            1:       begin ir = ifa.inst_ready;  bi = {1'b0, bit_idxa}; end
            default: begin ir = if16.inst_ready; bi = bit_idx16;        end
        endcase
        return {ir, busy_o[i], alu_start_o[i], alu_op_o[i], carry_o[i], shift_o[i],
                accw_o[i], accl_o[i], store_o[i], bi, done_o[i], ill_o[i]};
    endfunction

    // Per-cycle comparison of every instance against the model, and done spacing in auto-run
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int i = 0; i < 3; i++) begin
                    logic [16:0] a;
                    logic [16:0] e;
                    a = get_act(i);
                    e = exp_vec(i);
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL model_cmp dut%0d cyc %0d actual %h required %h", i, cyc, a, e);
                    end
                end
                if (ua_win && done_o[1]) begin
                    if (ua_last >= 0) begin
                        checks++;
                        if (cyc - ua_last != 11) begin
                            errors++;
                            $display("FAIL auto_done_period actual %0d required 11", cyc - ua_last);
                        end
                    end
                    ua_last = cyc;
                end
            end
        end
    end

    // ---------------- directed stimulus -------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic accept8(input logic [3:0] op);
        if8.opcode     = op;
        if8.inst_valid = 1'b1;
        stp[0]         = 1'b1;
        tick();
        stp[0]         = 1'b0;
        if8.inst_valid = 1'b0;
        if8.opcode     = 4'hF;
    endtask

    task automatic short_op(input logic [3:0] op, input int e_load, input int e_store, input int e_ill);
        accept8(op);
        chk("short_load_t1",  int'(accl_o[0]),  e_load);
        chk("short_store_t1", int'(store_o[0]), e_store);
        chk("short_shift_t1", int'(shift_o[0]), 0);
        tick();
        chk("short_done_t2",    int'(done_o[0]), 1);
        chk("short_illegal_t2", int'(ill_o[0]),  e_ill);
        tick();
    endtask

    initial begin
        int nsh;
        int done_at;
        for (int i = 0; i < 3; i++) begin
            stp[i] = 1'b0;
            abt[i] = 1'b0;
        end
        if8.inst_valid  = 1'b0; if8.opcode  = 4'h0;
        ifa.inst_valid  = 1'b0; ifa.opcode  = 4'h0;
        if16.inst_valid = 1'b0; if16.opcode = 4'h0;

        rst_n = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("reset_ready", int'(if8.inst_ready), 1);
        chk("reset_busy",  int'(busy_o[0]), 0);
        rst_n = 1'b1;
        tick();

        // Auto-run instance streams SUB while the step-mode instance is exercised
        ifa.opcode     = 4'h1;
        ifa.inst_valid = 1'b1;
        ua_last        = -1;
        ua_win         = 1'b1;

        // ADD, 8-bit, step mode
        accept8(4'h0);
        chk("add_ready_t1", int'(if8.inst_ready), 0);
        chk("add_start_t1", int'(alu_start_o[0]), 1);
        chk("add_shift_t1", int'(shift_o[0]), 1);
        chk("add_accw_t1",  int'(accw_o[0]), 0);
        tick();
        chk("add_bitidx_t2", int'(bit_idx8), 1);
        chk("add_start_t2",  int'(alu_start_o[0]), 0);
        chk("add_accw_t2",   int'(accw_o[0]), 1);
        repeat (6) tick();
        chk("add_bitidx_t8", int'(bit_idx8), 7);
        chk("add_shift_t8",  int'(shift_o[0]), 1);
        tick();
        chk("add_shift_t9", int'(shift_o[0]), 0);
        chk("add_accw_t9",  int'(accw_o[0]), 1);
        tick();
        chk("add_done_t10", int'(done_o[0]), 1);
        tick();
        chk("add_ready_t11", int'(if8.inst_ready), 1);
        chk("add_done_t11",  int'(done_o[0]), 0);

        // Load-immediate, store, illegal
        short_op(4'hD, 1, 0, 0);
        short_op(4'hE, 0, 1, 0);
        short_op(4'hF, 0, 0, 1);

        repeat (25) tick();
        ifa.inst_valid = 1'b0;
        ua_win         = 1'b0;
        repeat (12) tick();

        // Abort mid-ALU op, then a fresh step two cycles later
        accept8(4'h1);
        repeat (3) tick();
        abt[0] = 1'b1;
        tick();
        abt[0] = 1'b0;
        chk("abort_ready_t5", int'(if8.inst_ready), 1);
        chk("abort_busy_t5",  int'(busy_o[0]), 0);
        tick();
        accept8(4'h3);
        chk("after_abort_busy",  int'(busy_o[0]), 1);
        chk("after_abort_aluop", int'(alu_op_o[0]), 6);
        repeat (10) tick();
        chk("after_abort_ready", int'(if8.inst_ready), 1);

        // Synchronous reset mid-instruction
        accept8(4'h0);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_busy_t4",  int'(busy_o[0]), 0);
        chk("rst_ready_t4", int'(if8.inst_ready), 1);
        tick();
        rst_n = 1'b1;
        chk("rst_busy_t5", int'(busy_o[0]), 0);
        chk("rst_done_t5", int'(done_o[0]), 0);
        accept8(4'h8);
        repeat (9) tick();
        chk("post_rst_done_t10", int'(done_o[0]), 1);
        chk("post_rst_ready_t10", int'(if8.inst_ready), 0);
        tick();

        // 16-bit SLLI with stray step pulses while busy
        if16.opcode     = 4'h2;
        if16.inst_valid = 1'b1;
        stp[2]          = 1'b1;
        tick();
        chk("w16_aluop_t1", int'(alu_op_o[2]), 5);
        nsh     = 0;
        done_at = -1;
        for (int t = 1; t <= 20; t++) begin
            if (shift_o[2]) nsh++;
            if (done_o[2] && (done_at < 0)) done_at = t;
            if ((t == 3) || (t == 7)) begin
                stp[2]          = 1'b1;
                if16.inst_valid = 1'b1;
                if16.opcode     = 4'hF;
            end else begin
                stp[2]          = 1'b0;
                if16.inst_valid = 1'b0;
            end
            tick();
        end
        chk("w16_shift_cycles", nsh, 16);
        chk("w16_done_cycle",   done_at, 18);
        chk("w16_ready_end",    int'(if16.inst_ready), 1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
